mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between the fetch and data ports.
// Active-low acknowledges on both sides; a watchdog closes transactions that never see m_ack_n.
module mem_bus_arbiter #(
  parameter int                   BIT_WIDTH = 32,
  parameter int                   TIMEOUT   = 16,
  parameter logic [BIT_WIDTH-1:0] NOP_INST  = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [BIT_WIDTH-1:0] i_addr,
  output logic [BIT_WIDTH-1:0] i_rdata,
  output logic                 i_ack_n,
  input  logic                 d_req,
  input  logic                 d_write,
  input  logic [1:0]           d_size,
  input  logic [BIT_WIDTH-1:0] d_addr,
  input  logic [BIT_WIDTH-1:0] d_wdata,
  output logic [BIT_WIDTH-1:0] d_rdata,
  output logic                 d_ack_n,
  output logic                 m_req,
  output logic                 m_write,
  output logic [1:0]           m_size,
  output logic [BIT_WIDTH-1:0] m_addr,
  output logic [BIT_WIDTH-1:0] m_wdata,
  input  logic [BIT_WIDTH-1:0] m_rdata,
  input  logic                 m_ack_n,
  output logic                 bus_err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t                 state_q, state_d;
  logic                   last_d_q, last_d_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0]             size_q, size_d;
  logic                   write_q, write_d;
  logic [BIT_WIDTH-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic                   i_ack_n_q, i_ack_n_d, d_ack_n_q, d_ack_n_d;
  logic                   bus_err_q, bus_err_d;
  logic                   timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    write_d   = write_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_n_d = 1'b1;
    d_ack_n_d = 1'b1;
    bus_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        // D wins a conflict unless it also won the previous grant.
        if (d_req && (!i_req || !last_d_q)) begin
          state_d = GNT_D;
          cnt_d   = '0;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          size_d  = d_size;
          write_d = d_write;
        end else if (i_req) begin
          state_d = GNT_I;
          cnt_d   = '0;
          addr_d  = i_addr;
          size_d  = 2'b00;
          write_d = 1'b0;
        end
      end
      GNT_I: begin
        if (!m_ack_n) begin
          i_ack_n_d = 1'b0;
          i_rdata_d = m_rdata;
          last_d_d  = 1'b0;
          state_d   = IDLE;
        end else if (timeout_hit) begin
          i_ack_n_d = 1'b0;
          bus_err_d = 1'b1;
          i_rdata_d = NOP_INST;
          last_d_d  = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GNT_D: begin
        if (!m_ack_n) begin
          d_ack_n_d = 1'b0;
          if (!write_q) d_rdata_d = m_rdata;
          last_d_d  = 1'b1;
          state_d   = IDLE;
        end else if (timeout_hit) begin
          d_ack_n_d = 1'b0;
          bus_err_d = 1'b1;
          if (!write_q) d_rdata_d = '0;
          last_d_d  = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= 2'b00;
      write_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_n_q <= 1'b1;
      d_ack_n_q <= 1'b1;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      write_q   <= write_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_n_q <= i_ack_n_d;
      d_ack_n_q <= d_ack_n_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign m_req   = (state_q != IDLE);
  assign m_write = write_q;
  assign m_size  = size_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack_n = i_ack_n_q;
  assign d_ack_n = d_ack_n_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a table of single transactions plus
// hand-written contention, idle-ack and reset-mid-grant sequences.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_write, m_ack_n;
  logic [1:0]  d_size;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_ack_n, d_ack_n, m_req, m_write, bus_err;
  logic [1:0]  m_size;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.BIT_WIDTH(32), .TIMEOUT(16), .NOP_INST(32'h0000_0013)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack_n(i_ack_n),
    .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack_n(d_ack_n),
    .m_req(m_req), .m_write(m_write), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack_n(m_ack_n), .bus_err(bus_err)
  );

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          wait_n;     // grant cycle index carrying m_ack_n=0; >=16 means never
    logic [31:0] exp_rdata;  // owner rdata after completion
    logic        exp_err;
    int          exp_cycles; // grant cycles until owner ack
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_req = 0; d_req = 0; d_write = 0; d_size = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0; m_ack_n = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    logic [31:0] oth_rdata;
    @(negedge clk);
    if (v.is_d) begin
      d_req = 1; d_write = v.wr; d_size = v.size; d_addr = v.addr; d_wdata = v.wdata;
      oth_rdata = i_rdata;
    end else begin
      i_req = 1; i_addr = v.addr;
      oth_rdata = d_rdata;
    end
    @(negedge clk);
    chk($sformatf("v%0d m_req", idx), {31'd0, m_req}, 32'd1);
    chk($sformatf("v%0d m_addr", idx), m_addr, v.addr);
    chk($sformatf("v%0d m_write", idx), {31'd0, m_write}, {31'd0, v.is_d & v.wr});
    chk($sformatf("v%0d m_size", idx), {30'd0, m_size}, v.is_d ? {30'd0, v.size} : 32'd0);
    if (v.is_d && v.wr) chk($sformatf("v%0d m_wdata", idx), m_wdata, v.wdata);
    i_req = 0; d_req = 0;
    n = 0;
    forever begin
      m_ack_n = (n == v.wait_n) ? 1'b0 : 1'b1;
      m_rdata = v.mrdata;
      @(negedge clk);
      m_ack_n = 1;
      n++;
      if ((v.is_d ? d_ack_n : i_ack_n) === 1'b0) break;
      chk($sformatf("v%0d hold m_req", idx), {31'd0, m_req}, 32'd1);
      chk($sformatf("v%0d hold m_addr", idx), m_addr, v.addr);
      if (n > 40) begin
        chk($sformatf("v%0d ack timeout", idx), 32'd0, 32'd1);
        break;
      end
    end
    chk($sformatf("v%0d cycles", idx), n, v.exp_cycles);
    chk($sformatf("v%0d rdata", idx), v.is_d ? d_rdata : i_rdata, v.exp_rdata);
    chk($sformatf("v%0d other rdata", idx), v.is_d ? i_rdata : d_rdata, oth_rdata);
    chk($sformatf("v%0d bus_err", idx), {31'd0, bus_err}, {31'd0, v.exp_err});
    chk($sformatf("v%0d other ack", idx), {31'd0, v.is_d ? i_ack_n : d_ack_n}, 32'd1);
    chk($sformatf("v%0d m_req idle", idx), {31'd0, m_req}, 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d ack pulse end", idx), {31'd0, v.is_d ? d_ack_n : i_ack_n}, 32'd1);
    chk($sformatf("v%0d err pulse end", idx), {31'd0, bus_err}, 32'd0);
  endtask

  initial begin
    //         is_d wr size  addr           wdata          mrdata         wait exp_rdata     err cyc
    tbl[0] = '{1'b0, 1'b0, 2'd0, 32'h0000_0100, 32'h0,         32'h0050_0093, 0,  32'h0050_0093, 1'b0, 1};
    tbl[1] = '{1'b1, 1'b1, 2'd0, 32'h0800_0010, 32'hDEAD_BEEF, 32'h1234_5678, 0,  32'h0000_0000, 1'b0, 1};
    tbl[2] = '{1'b1, 1'b0, 2'd2, 32'h0800_0020, 32'h0,         32'h0000_00AB, 1,  32'h0000_00AB, 1'b0, 2};
    tbl[3] = '{1'b0, 1'b0, 2'd0, 32'h0000_0104, 32'h0,         32'h0010_8093, 3,  32'h0010_8093, 1'b0, 4};
    tbl[4] = '{1'b0, 1'b0, 2'd0, 32'h0000_0108, 32'h0,         32'h5555_5555, 99, 32'h0000_0013, 1'b1, 16};
    tbl[5] = '{1'b0, 1'b0, 2'd0, 32'h0000_010C, 32'h0,         32'h1111_1111, 15, 32'h1111_1111, 1'b0, 16};
    tbl[6] = '{1'b1, 1'b0, 2'd0, 32'h0000_0040, 32'h0,         32'h7777_7777, 99, 32'h0000_0000, 1'b1, 16};
    tbl[7] = '{1'b1, 1'b0, 2'd1, 32'h0000_0044, 32'h0,         32'hCAFE_F00D, 0,  32'hCAFE_F00D, 1'b0, 1};
    tbl[8] = '{1'b1, 1'b1, 2'd3, 32'h0000_0048, 32'h0000_00EE, 32'h9999_9999, 99, 32'hCAFE_F00D, 1'b1, 16};

    do_reset();
    @(negedge clk);
    chk("rst m_req", {31'd0, m_req}, 32'd0);
    chk("rst m_write", {31'd0, m_write}, 32'd0);
    chk("rst m_size", {30'd0, m_size}, 32'd0);
    chk("rst m_addr", m_addr, 32'd0);
    chk("rst m_wdata", m_wdata, 32'd0);
    chk("rst i_rdata", i_rdata, 32'd0);
    chk("rst d_rdata", d_rdata, 32'd0);
    chk("rst i_ack_n", {31'd0, i_ack_n}, 32'd1);
    chk("rst d_ack_n", {31'd0, d_ack_n}, 32'd1);
    chk("rst bus_err", {31'd0, bus_err}, 32'd0);

    // m_ack_n low while idle must be ignored
    m_ack_n = 0; m_rdata = 32'hFFFF_FFFF;
    repeat (2) begin
      @(negedge clk);
      chk("idle ack i_ack_n", {31'd0, i_ack_n}, 32'd1);
      chk("idle ack d_ack_n", {31'd0, d_ack_n}, 32'd1);
      chk("idle ack i_rdata", i_rdata, 32'd0);
      chk("idle ack m_req", {31'd0, m_req}, 32'd0);
    end
    m_ack_n = 1;

    for (int k = 0; k < 9; k++) run_vec(k, tbl[k]);

    // Contention from reset: order D, I, D, I with single-cycle acks
    do_reset();
    d_req = 1; d_addr = 32'h0000_0D00; d_write = 0; d_size = 0;
    i_req = 1; i_addr = 32'h0000_0100;
    for (int g = 0; g < 4; g++) begin
      logic exp_d;
      int wt;
      exp_d = (g % 2 == 0);
      wt = 0;
      @(negedge clk);
      while (m_req !== 1'b1 && wt < 5) begin
        @(negedge clk);
        wt++;
      end
      chk($sformatf("cont g%0d granted", g), {31'd0, m_req}, 32'd1);
      chk($sformatf("cont g%0d owner addr", g), m_addr, exp_d ? 32'h0000_0D00 : 32'h0000_0100);
      m_ack_n = 0; m_rdata = 32'hA000_0000 + g;
      @(negedge clk);
      m_ack_n = 1;
      chk($sformatf("cont g%0d d_ack_n", g), {31'd0, d_ack_n}, {31'd0, ~exp_d});
      chk($sformatf("cont g%0d i_ack_n", g), {31'd0, i_ack_n}, {31'd0, exp_d});
      chk($sformatf("cont g%0d rdata", g), exp_d ? d_rdata : i_rdata, 32'hA000_0000 + g);
      chk($sformatf("cont g%0d idle", g), {31'd0, m_req}, 32'd0);
    end
    @(negedge clk);
    chk("cont ack single d", {31'd0, d_ack_n}, 32'd1);
    chk("cont ack single i", {31'd0, i_ack_n}, 32'd1);
    chk("cont next grant", {31'd0, m_req}, 32'd1);
    idle_inputs();
    m_ack_n = 0;
    @(negedge clk);
    m_ack_n = 1;
    @(negedge clk);

    // Reset mid-grant: dropped D transaction, pending fetch served after release
    do_reset();
    @(negedge clk);
    d_req = 1; d_addr = 32'h0000_0200;
    @(negedge clk);
    chk("rstmid in GNT_D", {31'd0, m_req}, 32'd1);
    d_req = 0; i_req = 1; i_addr = 32'h0000_0300;
    #2 rst = 0;
    #1;
    chk("rstmid m_req falls", {31'd0, m_req}, 32'd0);
    chk("rstmid no d_ack", {31'd0, d_ack_n}, 32'd1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rstmid fetch m_req", {31'd0, m_req}, 32'd1);
    chk("rstmid fetch addr", m_addr, 32'h0000_0300);
    chk("rstmid still no d_ack", {31'd0, d_ack_n}, 32'd1);
    i_req = 0; m_ack_n = 0; m_rdata = 32'h0000_0513;
    @(negedge clk);
    m_ack_n = 1;
    chk("rstmid fetch ack", {31'd0, i_ack_n}, 32'd0);
    chk("rstmid fetch rdata", i_rdata, 32'h0000_0513);
    chk("rstmid d_ack after", {31'd0, d_ack_n}, 32'd1);
    chk("rstmid no bus_err", {31'd0, bus_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
